// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU time-sharing arbiter.
//   - ALU_Sel opcode constants for the 4-bit ALU core
//   - FSM state enum for the arbiter sequencer
//   - Operand (DW) and opcode (OPW) width constants
package alu_share_pkg;

    localparam int unsigned DW  = 4;
    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OpAdd = 3'b000;
    localparam logic [OPW-1:0] OpSub = 3'b001;
    localparam logic [OPW-1:0] OpAnd = 3'b010;
    localparam logic [OPW-1:0] OpOr  = 3'b011;
    localparam logic [OPW-1:0] OpXor = 3'b100;
    localparam logic [OPW-1:0] OpNor = 3'b101;
    localparam logic [OPW-1:0] OpShl = 3'b110;
    localparam logic [OPW-1:0] OpShr = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Existing 4-bit combinational ALU core.
// Ports:
//   A, B      in  4  operands
//   ALU_Sel   in  3  operation select (all 8 codes defined)
//   ALU_Out   out 4  result
//   CarryOut  out 1  carry for ADD, borrow for SUB, shifted-out bit for SHL/SHR, else 0
module alu_core
    import alu_share_pkg::*;
(
    input  logic [DW-1:0]  A,
    input  logic [DW-1:0]  B,
    input  logic [OPW-1:0] ALU_Sel,
    output logic [DW-1:0]  ALU_Out,
    output logic           CarryOut
);

    // Bit 4 carries the carry/borrow/shifted-out bit.
    logic [DW:0] wide;

    always_comb begin
        wide = '0;
        case (ALU_Sel)
            OpAdd:   wide = {1'b0, A} + {1'b0, B};
            OpSub:   wide = {1'b0, A} - {1'b0, B};
            OpAnd:   wide = {1'b0, A & B};
            OpOr:    wide = {1'b0, A | B};
            OpXor:   wide = {1'b0, A ^ B};
            OpNor:   wide = {1'b0, ~(A | B)};
            OpShl:   wide = {A, 1'b0};
            OpShr:   wide = {A[0], 1'b0, A[DW-1:1]};
            default: wide = '0;
        endcase
    end

    assign ALU_Out  = wide[DW-1:0];
    assign CarryOut = wide[DW];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request searching from
// last_grant_i+1 and wrapping modulo NUM_REQ.
// Ports:
//   req_i         in  NUM_REQ  request vector
//   last_grant_i  in  ID_W     index of the previous winner
//   enable_i      in  1        gates the one-hot grant
//   grant_o       out NUM_REQ  one-hot grant (zero when disabled or no request)
//   grant_idx_o   out ID_W     encoded winner; the search start when nothing requests
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic            found;
    logic [ID_W-1:0] cur;
    int unsigned     start;

    always_comb begin
        found       = 1'b0;
        start       = (32'(last_grant_i) + 32'd1) % NUM_REQ;
        cur         = ID_W'(start);
        grant_idx_o = ID_W'(start);
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cur = ID_W'((start + k) % NUM_REQ);
            if (!found && req_i[cur]) begin
                found       = 1'b1;
                grant_idx_o = cur;
            end
        end
        grant_o = '0;
        if (found && enable_i) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer time-sharing one 4-bit ALU among NUM_REQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (1 cycle, ALU sees
// registered operands) -> RESP (hold response until rsp_ready).
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot, IDLE only)
//   req_a/req_b/req_op      packed per-requester operands and ALU_Sel
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_result/rsp_carry  registered, tagged response
//   busy                    state is not IDLE
//   op_count                completed responses, wraps at 256
// Build option ALU_OPERAND_ISOLATION_EN: when defined, operand registers load
// only on an accept. When undefined they follow the round-robin candidate on
// every IDLE cycle. Port behaviour is identical either way.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [DW*NUM_REQ-1:0]  req_a,
    input  logic [DW*NUM_REQ-1:0]  req_b,
    input  logic [OPW*NUM_REQ-1:0] req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DW-1:0]          rsp_result,
    output logic                   rsp_carry,
    output logic                   busy,
    output logic [7:0]             op_count
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DW-1:0]      opa_q, opa_d;
    logic [DW-1:0]      opb_q, opb_d;
    logic [OPW-1:0]     op_q, op_d;
    logic [DW-1:0]      rsp_result_q, rsp_result_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic [7:0]         op_count_q, op_count_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [DW-1:0]      cand_a, cand_b, alu_out;
    logic [OPW-1:0]     cand_op;
    logic               alu_carry, in_idle, accept, load_ops;

    assign in_idle = (state_q == StIdle);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (in_idle),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // Operand slices of the current round-robin candidate.
    assign cand_a  = DW'(req_a >> (DW * 32'(grant_idx)));
    assign cand_b  = DW'(req_b >> (DW * 32'(grant_idx)));
    assign cand_op = OPW'(req_op >> (OPW * 32'(grant_idx)));

    assign accept = in_idle && |(req_valid & grant);

`ifdef ALU_OPERAND_ISOLATION_EN
    assign load_ops = accept;
`else
    assign load_ops = in_idle;
`endif

    alu_core u_alu (
        .A        (opa_q),
        .B        (opb_q),
        .ALU_Sel  (op_q),
        .ALU_Out  (alu_out),
        .CarryOut (alu_carry)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        rsp_id_d     = rsp_id_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        op_count_d   = op_count_q;

        if (load_ops) begin
            opa_d = cand_a;
            opb_d = cand_b;
            op_d  = cand_op;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cur_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = StExec;
                end
            end
            StExec: begin
                rsp_result_d = alu_out;
                rsp_carry_d  = alu_carry;
                rsp_id_d     = cur_id_q;
                state_d      = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cur_id_q     <= '0;
            rsp_id_q     <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            rsp_id_q     <= rsp_id_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = grant;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = !in_idle;
    assign op_count   = op_count_q;

endmodule
